// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with byte strobes, valid/ready requests, a flagged
// one-cycle read response and a sequencer that zero-fills the array on reset or command.
module ram_sp_clr #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    input  logic                clear,
    output logic                busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                accept;
    logic                wr_acc;
    logic                rd_acc;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_be;

    assign req_ready = (state_q == S_RUN) & ~rst;
    assign accept    = req_valid & req_ready;
    assign wr_acc    = accept & rw;
    assign rd_acc    = accept & ~rw;

    assign busy      = (state_q == S_CLEAR);
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;

    // The sequencer owns the single write port while clearing; requests cannot be
    // accepted then because req_ready is low, so the two sources never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wdata;
        mem_be    = wstrb;
        if (state_q == S_CLEAR && !rst) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;

        if (rd_acc) begin
            rdata_d  = mem[addr];
            rvalid_d = 1'b1;
        end

        case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A request accepted on the same edge is still serviced above;
                // a same-edge write is then overwritten by the fill.
                if (clear) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = S_RUN;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr: one instance clearing on reset, one not.
module tb_ram_sp_clr;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;

    logic          a_rst = 1'b1, a_req_valid = 1'b0, a_rw = 1'b0, a_clear = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic [3:0]    a_wstrb = '0;
    logic          a_req_ready, a_rvalid, a_busy;
    logic [DW-1:0] a_rdata;

    logic          b_rst = 1'b1, b_req_valid = 1'b0, b_rw = 1'b0, b_clear = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic [3:0]    b_wstrb = '0;
    logic          b_req_ready, b_rvalid, b_busy;
    logic [DW-1:0] b_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    ram_sp_clr #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .rw(a_rw), .addr(a_addr), .wdata(a_wdata), .wstrb(a_wstrb),
        .rdata(a_rdata), .rvalid(a_rvalid), .clear(a_clear), .busy(a_busy)
    );

    ram_sp_clr #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .rw(b_rw), .addr(b_addr), .wdata(b_wdata), .wstrb(b_wstrb),
        .rdata(b_rdata), .rvalid(b_rvalid), .clear(b_clear), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] s);
        a_req_valid = 1'b1; a_rw = 1'b1; a_addr = ad; a_wdata = d; a_wstrb = s;
        step();
        a_req_valid = 1'b0; a_rw = 1'b0;
        check("wr_rvalid_low", {31'd0, a_rvalid}, 32'd0);
    endtask

    task automatic a_read(input string tag, input logic [AW-1:0] ad, input logic [31:0] exp);
        a_req_valid = 1'b1; a_rw = 1'b0; a_addr = ad;
        step();
        a_req_valid = 1'b0;
        check({tag, "_rvalid"}, {31'd0, a_rvalid}, 32'd1);
        check({tag, "_rdata"}, a_rdata, exp);
    endtask

    task automatic count_busy(input string tag);
        cnt = 0;
        while (a_busy && cnt < 5000) begin
            cnt++;
            a_clear = (cnt < 10) ? a_clear : 1'b0;
            step();
        end
        a_clear = 1'b0;
        check(tag, cnt, 32'd1024);
        check({tag, "_ready"}, {31'd0, a_req_ready}, 32'd1);
    endtask

    initial begin
        // Reset of the clear-on-reset instance
        step();
        check("rst_ready", {31'd0, a_req_ready}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd1);
        check("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        a_rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, a_req_ready}, 32'd0);
        count_busy("init_clear_len");

        a_read("rd0", 10'd0, 32'h0);
        a_read("rd511", 10'd511, 32'h0);
        a_read("rd1023", 10'd1023, 32'h0);
        step();
        check("idle_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("idle_rdata_hold", a_rdata, 32'h0);

        // Byte strobes
        a_write(10'd5, 32'hAABBCCDD, 4'hF);
        a_write(10'd5, 32'h11223344, 4'b0010);
        a_read("strb", 10'd5, 32'hAABB33DD);
        a_write(10'd5, 32'hFFFFFFFF, 4'h0);
        a_read("strb0", 10'd5, 32'hAABB33DD);

        // Back-to-back write then read, then rdata holds
        a_write(10'd1023, 32'h12345678, 4'hF);
        a_read("b2b", 10'd1023, 32'h12345678);
        step();
        check("b2b_after_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("b2b_hold", a_rdata, 32'h12345678);

        // Clear colliding with a read
        a_write(10'd7, 32'h000000FF, 4'hF);
        a_clear = 1'b1; a_req_valid = 1'b1; a_rw = 1'b0; a_addr = 10'd7;
        step();
        a_clear = 1'b0; a_req_valid = 1'b0;
        check("coll_rd_rvalid", {31'd0, a_rvalid}, 32'd1);
        check("coll_rd_rdata", a_rdata, 32'h000000FF);
        check("coll_rd_busy", {31'd0, a_busy}, 32'd1);
        check("coll_rd_ready", {31'd0, a_req_ready}, 32'd0);
        count_busy("coll_rd_len");
        a_read("coll_rd_after", 10'd7, 32'h0);
        a_read("coll_rd_a5", 10'd5, 32'h0);

        // Clear colliding with a write
        a_clear = 1'b1; a_req_valid = 1'b1; a_rw = 1'b1; a_addr = 10'd7;
        a_wdata = 32'h55; a_wstrb = 4'hF;
        step();
        a_clear = 1'b0; a_req_valid = 1'b0; a_rw = 1'b0;
        check("coll_wr_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("coll_wr_busy", {31'd0, a_busy}, 32'd1);
        count_busy("coll_wr_len");
        a_read("coll_wr_after", 10'd7, 32'h0);

        // Reset when clr_addr reaches 300; clear held during the restarted sequence
        a_write(10'd900, 32'hCAFEF00D, 4'hF);
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        repeat (300) step();
        check("mid_busy", {31'd0, a_busy}, 32'd1);
        a_rst = 1'b1;
        step();
        check("mid_rst_busy", {31'd0, a_busy}, 32'd1);
        a_rst = 1'b0;
        a_clear = 1'b1;
        count_busy("mid_rst_len");
        a_read("mid_rst_a900", 10'd900, 32'h0);

        // Instance without clear on reset
        step();
        check("b_rst_ready", {31'd0, b_req_ready}, 32'd0);
        b_rst = 1'b0;
        #1;
        check("b_ready", {31'd0, b_req_ready}, 32'd1);
        check("b_busy", {31'd0, b_busy}, 32'd0);
        check("b_rvalid", {31'd0, b_rvalid}, 32'd0);
        check("b_rdata", b_rdata, 32'd0);
        b_req_valid = 1'b1; b_rw = 1'b1; b_addr = '0; b_wdata = 32'hDEADBEEF; b_wstrb = 4'hF;
        step();
        b_rw = 1'b0;
        check("b_wr_rvalid", {31'd0, b_rvalid}, 32'd0);
        step();
        b_req_valid = 1'b0;
        check("b_rd_rvalid", {31'd0, b_rvalid}, 32'd1);
        check("b_rd_rdata", b_rdata, 32'hDEADBEEF);
        step();
        check("b_idle_rvalid", {31'd0, b_rvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
